// File: rtl/fetch_queue_stage.sv
// -----------------------------------------------------------------------------
// fetch_queue_stage
//   Instruction-fetch front end. Owns the program counter, issues one request
//   per cycle to a synchronous instruction memory (data returns one cycle after
//   the request) and buffers returned words in a small FIFO that feeds decode
//   through a valid/ready handshake. A start-address load (pcSelect) and a
//   branch/jump redirect both flush the queue and drop the in-flight response.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   pcSelect          1 = load startAddress into PC, flush, hold fetch
//   startAddress      PC loaded while pcSelect=1 (low 2 bits ignored)
//   redirect_valid    taken branch/jump from execute
//   redirect_target   new PC on redirect (low 2 bits ignored)
//   imem_req          fetch request this cycle (combinational)
//   imem_addr         byte address of the request (registered PC)
//   imem_rdata        memory data, valid the cycle after imem_req
//   id_valid          queue head valid to decode
//   id_instr, id_pc   head instruction and its PC (0 while id_valid=0)
//   id_ready          decode accepts the head this cycle
// -----------------------------------------------------------------------------
module fetch_queue_stage #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    QDEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pcSelect,
  input  logic [ADDR_WIDTH-1:0]  startAddress,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   id_valid,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [ADDR_WIDTH-1:0]  id_pc,
  input  logic                   id_ready
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(QDEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_pc, w_pc_nxt;
  logic [ADDR_WIDTH-1:0]   r_req_pc;
  logic                    r_inflight;
  logic                    r_discard;
  logic [CW-1:0]           r_count;
  logic [PW-1:0]           r_rd_ptr, r_wr_ptr;
  logic [INSTR_WIDTH-1:0]  r_instr_mem [QDEPTH];
  logic [ADDR_WIDTH-1:0]   r_pc_mem    [QDEPTH];

  logic                    w_flush, w_pop, w_push, w_req;
  logic [CW:0]             w_occ;

  assign w_flush = pcSelect | redirect_valid;
  assign w_pop   = id_valid & id_ready & ~w_flush;
  // The response of the request issued last cycle lands now; it is dropped if
  // a flush happened last cycle or is happening this cycle.
  assign w_push  = r_inflight & ~r_discard & ~w_flush;

  // Occupancy including the word already in flight, net of this cycle's pop.
  // A pop implies r_count >= 1, so the subtraction cannot underflow.
  assign w_occ = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

  // Next-state, next-PC and request decode.
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req       = 1'b0;
    if (pcSelect) begin
      w_state_nxt = S_LOAD;
      w_pc_nxt    = startAddress & ALIGN_MASK;
    end else begin
      w_state_nxt = S_RUN;
      if (redirect_valid) begin
        w_pc_nxt = redirect_target & ALIGN_MASK;
      end else if (r_state == S_RUN && w_occ < {1'b0, DEPTH_C}) begin
        w_req    = 1'b1;
        w_pc_nxt = r_pc + ADDR_WIDTH'(4);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOAD;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inflight <= w_req;
      r_discard  <= w_flush;
      if (w_req) r_req_pc <= r_pc;
      if (w_flush) begin
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; occupancy is tracked by
  // r_count and the outputs are gated with id_valid, so stale contents are
  // never visible and the array can map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_req_pc;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign id_valid  = (r_count != '0);
  assign id_instr  = id_valid ? r_instr_mem[r_rd_ptr] : '0;
  assign id_pc     = id_valid ? r_pc_mem[r_rd_ptr]    : '0;

  // Request throttling guarantees room for every response.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && r_count == DEPTH_C));

endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
- Instruction-fetch front end of the pipeline: owns the program counter, issues requests to the synchronous instruction memory, and buffers returned instructions in a small FIFO.
- Feeds decode through a valid/ready handshake.
- Supports a start-address load (pcSelect/startAddress) and a branch/jump redirect from the execute stage.
- Sits between the instruction memory and the decode stage.

Parameters:
- ADDR_WIDTH, 32, width of PC, startAddress, redirect target and imem_addr.
- INSTR_WIDTH, 32, instruction word width.
- QDEPTH, 4, instruction queue entries; must be a power of two and ≥2.
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- pcSelect  input  1  1 = load startAddress into PC, flush, and hold fetch.
- startAddress  input  ADDR_WIDTH  start PC used while pcSelect=1.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_target  input  ADDR_WIDTH  new PC on redirect.
- imem_req  output  1  fetch request this cycle.
- imem_addr  output  ADDR_WIDTH  word address of the request (byte address, low 2 bits 0).
- imem_rdata  input  INSTR_WIDTH  read data, valid exactly 1 cycle after imem_req.
- id_valid  output  1  queue head valid to decode.
- id_instr  output  INSTR_WIDTH  head instruction.
- id_pc  output  ADDR_WIDTH  PC of the head instruction.
- id_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset (rst_n=0, async):
  - pc=RESET_PC, state=LOAD, count=0, inflight=0, rd/wr pointers=0.
  - Outputs: id_valid=0, id_instr=0, id_pc=0, imem_req=0, imem_addr=RESET_PC.
- States:
  - LOAD: pcSelect=1 or just out of reset.
  - RUN: fetching.
- LOAD→RUN: first rising edge with pcSelect=0.
- Any state→LOAD: pcSelect=1.
- Priority on a given edge: rst_n > pcSelect > redirect_valid > normal fetch/advance.
- pcSelect=1 (any state):
  - Next cycle: pc<=startAddress with low 2 bits forced 0.
  - Queue flushed (count=0, id_valid=0); in-flight response discarded; imem_req=0.
- imem_addr = pc (registered value, driven continuously).
- imem_req is combinational and asserts when all of the following hold:
  - state=RUN, pcSelect=0, redirect_valid=0;
  - (count + inflight − pop_this_cycle) < QDEPTH.
- When imem_req=1:
  - pc<=pc+4, wrapping modulo 2^ADDR_WIDTH.
  - req_pc<=pc, inflight<=1.
  - Otherwise inflight<=0.
- Response: in the cycle after a request (inflight=1), {imem_rdata, req_pc} is pushed into the queue, unless a discard is pending.
- Overflow cannot occur by construction; a push into a full queue is an assertion failure.
- Redirect (redirect_valid=1, pcSelect=0):
  - pc<=redirect_target with low 2 bits forced 0; queue flushed.
  - Any response arriving next cycle is dropped (discard flag set for one cycle).
  - No request is issued in the redirect cycle.
  - Fetch resumes the following cycle: first imem_req with imem_addr=target.
- Output: id_valid = (count≠0); id_instr/id_pc driven from the head entry.
  - Pop occurs when id_valid & id_ready & no flush this cycle.
  - Head data stays stable while id_valid=1 and id_ready=0.
- Simultaneous push and pop: count unchanged, both pointers advance; allowed at full and at empty+push (the pushed word appears on id_* the next cycle, not bypassed).
- Pointers wrap modulo QDEPTH.
- Latency:
  - Request to id_valid = 2 cycles (req, response/push, visible).
  - Steady-state throughput is 1 instr/cycle when id_ready=1 continuously.
- Reset asserted mid-fetch: everything clears immediately; any returning response is ignored (inflight=0).

Test Plan:
- Reset, startAddress=0x00000000, pcSelect=1 for 2 cycles then 0, id_ready=1 → imem_addr 0x0,0x4,0x8,… on consecutive cycles; first id_valid 2 cycles after first req with id_pc=0x0; id_pc increments by 4 every cycle thereafter.
- pcSelect pulse with startAddress=0x00000103 → PC loads 0x00000100; first request address 0x100; queued old instructions never reach decode.
- id_ready held 0, QDEPTH=4 → exactly 4 requests issued, then imem_req=0, id_valid=1, id_instr/id_pc frozen; release id_ready → 4 pops in order, fetch resumes with no lost or duplicated PC.
- redirect_valid=1, target 0x40 while a request for 0x10 is in flight → the 0x10 response is dropped; next id_pc observed is 0x40; no imem_req in the redirect cycle.
- PC near wrap, startAddress=0xFFFFFFFC → requests to 0xFFFFFFFC then 0x00000000; id_pc matches each.
- rst_n pulsed low mid-stream with 3 entries queued → id_valid=0 asynchronously, imem_req=0, pc=RESET_PC; the response arriving the next cycle is not enqueued.
